// File: rtl/wasm_loader_if.sv
// Byte-wide memory read bus shared between the boot loader and the ROM.
// The loader drives address and read enable; memory answers with data and ready.
interface wasm_loader_if;
  logic [31:0] addr;
  logic        memory_read_en;
  logic [7:0]  data_out;
  logic        memory_ready;

  modport master (output addr, output memory_read_en, input data_out, input memory_ready);
  modport slave  (input addr, input memory_read_en, output data_out, output memory_ready);
endinterface

// File: rtl/wasm_loader.sv
// Boot loader: walks a WebAssembly image in ROM, validates the header, locates the
// entry function body and publishes the address of its first opcode.
module wasm_loader #(
  parameter logic [31:0] ROM_BASE      = 32'h0,
  parameter int          MAX_LEB_BYTES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  wasm_loader_if.master        bus,
  input  logic [31:0]          rom_len,
  output logic                 rom_mapped,
  output logic [31:0]          first_instruction,
  output logic                 parse_error,
  output logic [2:0]           error_code
);

  typedef enum logic [3:0] {
    S_HDR, S_SEC_ID, S_SEC_SIZE, S_DISPATCH, S_START_IDX, S_CODE_CNT,
    S_BODY_SIZE, S_LOCAL_CNT, S_LOCAL_N, S_LOCAL_TYPE, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {RD_REQ, RD_WAIT, RD_REL} rd_t;

  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_VERSION = 3'd2;
  localparam logic [2:0] ERR_NO_CODE = 3'd3;
  localparam logic [2:0] ERR_LEB     = 3'd4;
  localparam logic [2:0] ERR_IMPORT  = 3'd5;
  localparam logic [2:0] ERR_TARGET  = 3'd6;
  localparam logic [2:0] ERR_RANGE   = 3'd7;

  state_t      r_state, w_state_nxt;
  rd_t         r_rd, w_rd_nxt;
  logic [31:0] r_cursor, w_cursor_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_read_en, w_read_en_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic [31:0] r_leb_acc, w_leb_acc_nxt;
  logic [2:0]  r_leb_cnt, w_leb_cnt_nxt;
  logic [2:0]  r_hdr_idx, w_hdr_idx_nxt;
  logic [7:0]  r_sec_id, w_sec_id_nxt;
  logic [31:0] r_sec_end, w_sec_end_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic [31:0] r_body_idx, w_body_idx_nxt;
  logic [31:0] r_local_rem, w_local_rem_nxt;
  logic [31:0] r_first, w_first_nxt;
  logic        r_mapped, w_mapped_nxt;
  logic        r_error, w_error_nxt;
  logic [2:0]  r_code, w_code_nxt;

  logic        w_reading, w_is_leb, w_byte_done;
  logic        w_fail;
  logic [2:0]  w_fail_code;
  logic [7:0]  w_hdr_exp;
  logic [4:0]  w_leb_shift;
  logic [31:0] w_leb_val;
  logic        w_leb_last, w_leb_over;
  logic [32:0] w_rom_end, w_cursor_plus;

  // End of ROM and cursor+LEB sums are kept 33 bits wide so wrap-around reads as out of range.
  assign w_rom_end     = {1'b0, ROM_BASE} + {1'b0, rom_len};
  assign w_leb_shift   = 5'd7 * {2'b00, r_leb_cnt};
  assign w_leb_val     = r_leb_acc | ({25'd0, r_byte[6:0]} << w_leb_shift);
  assign w_leb_last    = ~r_byte[7];
  assign w_leb_over    = r_byte[7] && ({29'd0, r_leb_cnt} == 32'(MAX_LEB_BYTES - 1));
  assign w_cursor_plus = {1'b0, r_cursor} + {1'b0, w_leb_val};

  assign w_reading = !(r_state inside {S_DISPATCH, S_DONE, S_ERROR});
  assign w_is_leb  = r_state inside {S_SEC_SIZE, S_START_IDX, S_CODE_CNT,
                                     S_BODY_SIZE, S_LOCAL_CNT, S_LOCAL_N};

  always_comb begin
    unique case (r_hdr_idx)
      3'd0:    w_hdr_exp = 8'h00;
      3'd1:    w_hdr_exp = 8'h61;
      3'd2:    w_hdr_exp = 8'h73;
      3'd3:    w_hdr_exp = 8'h6D;
      3'd4:    w_hdr_exp = 8'h01;
      default: w_hdr_exp = 8'h00;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_nxt        = r_rd;
    w_cursor_nxt    = r_cursor;
    w_addr_nxt      = r_addr;
    w_read_en_nxt   = r_read_en;
    w_byte_nxt      = r_byte;
    w_leb_acc_nxt   = r_leb_acc;
    w_leb_cnt_nxt   = r_leb_cnt;
    w_hdr_idx_nxt   = r_hdr_idx;
    w_sec_id_nxt    = r_sec_id;
    w_sec_end_nxt   = r_sec_end;
    w_target_nxt    = r_target;
    w_body_idx_nxt  = r_body_idx;
    w_local_rem_nxt = r_local_rem;
    w_first_nxt     = r_first;
    w_mapped_nxt    = r_mapped;
    w_error_nxt     = r_error;
    w_code_nxt      = r_code;
    w_byte_done     = 1'b0;
    w_fail          = 1'b0;
    w_fail_code     = 3'd0;

    // Shared byte fetch: request, wait for ready and capture, then wait for ready to drop.
    if (w_reading) begin
      unique case (r_rd)
        RD_REQ: begin
          if (r_state == S_SEC_ID && {1'b0, r_cursor} == w_rom_end) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_NO_CODE;
          end else if ({1'b0, r_cursor} >= w_rom_end) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_RANGE;
          end else begin
            w_addr_nxt    = r_cursor;
            w_read_en_nxt = 1'b1;
            w_rd_nxt      = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.memory_ready) begin
            w_byte_nxt    = bus.data_out;
            w_read_en_nxt = 1'b0;
            w_cursor_nxt  = r_cursor + 32'd1;
            w_rd_nxt      = RD_REL;
          end
        end
        RD_REL: begin
          if (!bus.memory_ready) begin
            w_rd_nxt    = RD_REQ;
            w_byte_done = 1'b1;
          end
        end
        default: w_rd_nxt = RD_REQ;
      endcase
    end

    if (w_byte_done) begin
      if (w_is_leb && w_leb_over) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_LEB;
      end else if (w_is_leb && !w_leb_last) begin
        w_leb_acc_nxt = w_leb_val;
        w_leb_cnt_nxt = r_leb_cnt + 3'd1;
      end else begin
        w_leb_acc_nxt = 32'd0;
        w_leb_cnt_nxt = 3'd0;
        unique case (r_state)
          S_HDR: begin
            if (r_byte != w_hdr_exp) begin
              w_fail      = 1'b1;
              w_fail_code = (r_hdr_idx < 3'd4) ? ERR_MAGIC : ERR_VERSION;
            end else if (r_hdr_idx == 3'd7) begin
              w_state_nxt = S_SEC_ID;
            end else begin
              w_hdr_idx_nxt = r_hdr_idx + 3'd1;
            end
          end
          S_SEC_ID: begin
            w_sec_id_nxt = r_byte;
            w_state_nxt  = S_SEC_SIZE;
          end
          S_SEC_SIZE: begin
            if (w_cursor_plus[32] || w_cursor_plus > w_rom_end) begin
              w_fail      = 1'b1;
              w_fail_code = ERR_RANGE;
            end else begin
              w_sec_end_nxt = w_cursor_plus[31:0];
              w_state_nxt   = S_DISPATCH;
            end
          end
          S_START_IDX: begin
            w_target_nxt = w_leb_val;
            w_cursor_nxt = r_sec_end;
            w_state_nxt  = S_SEC_ID;
          end
          S_CODE_CNT: begin
            if (r_target >= w_leb_val) begin
              w_fail      = 1'b1;
              w_fail_code = ERR_TARGET;
            end else begin
              w_body_idx_nxt = 32'd0;
              w_state_nxt    = S_BODY_SIZE;
            end
          end
          S_BODY_SIZE: begin
            if (r_body_idx == r_target) begin
              w_state_nxt = S_LOCAL_CNT;
            end else if (w_cursor_plus[32] || w_cursor_plus > w_rom_end) begin
              w_fail      = 1'b1;
              w_fail_code = ERR_RANGE;
            end else begin
              w_cursor_nxt   = w_cursor_plus[31:0];
              w_body_idx_nxt = r_body_idx + 32'd1;
            end
          end
          S_LOCAL_CNT: begin
            w_local_rem_nxt = w_leb_val;
            w_state_nxt     = (w_leb_val == 32'd0) ? S_DONE : S_LOCAL_N;
          end
          S_LOCAL_N: w_state_nxt = S_LOCAL_TYPE;
          S_LOCAL_TYPE: begin
            w_local_rem_nxt = r_local_rem - 32'd1;
            w_state_nxt     = (r_local_rem == 32'd1) ? S_DONE : S_LOCAL_N;
          end
          default: ;
        endcase
      end
    end

    // Dispatch consumes one cycle with no bus activity; unknown sections are jumped over.
    if (r_state == S_DISPATCH) begin
      if (r_sec_id == 8'd2 && r_sec_end != r_cursor) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_IMPORT;
      end else if (r_sec_id == 8'd8) begin
        w_state_nxt = S_START_IDX;
      end else if (r_sec_id == 8'd10) begin
        w_state_nxt = S_CODE_CNT;
      end else begin
        w_cursor_nxt = r_sec_end;
        w_state_nxt  = S_SEC_ID;
      end
    end

    if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      w_first_nxt   = w_cursor_nxt;
      w_mapped_nxt  = 1'b1;
      w_read_en_nxt = 1'b0;
    end

    if (w_fail) begin
      w_state_nxt   = S_ERROR;
      w_error_nxt   = 1'b1;
      w_code_nxt    = w_fail_code;
      w_read_en_nxt = 1'b0;
    end

    if (r_state == S_DONE || r_state == S_ERROR) begin
      w_read_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_rd        <= RD_REQ;
      r_cursor    <= ROM_BASE;
      r_addr      <= 32'd0;
      r_read_en   <= 1'b0;
      r_byte      <= 8'd0;
      r_leb_acc   <= 32'd0;
      r_leb_cnt   <= 3'd0;
      r_hdr_idx   <= 3'd0;
      r_sec_id    <= 8'd0;
      r_sec_end   <= 32'd0;
      r_target    <= 32'd0;
      r_body_idx  <= 32'd0;
      r_local_rem <= 32'd0;
      r_first     <= 32'd0;
      r_mapped    <= 1'b0;
      r_error     <= 1'b0;
      r_code      <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd        <= w_rd_nxt;
      r_cursor    <= w_cursor_nxt;
      r_addr      <= w_addr_nxt;
      r_read_en   <= w_read_en_nxt;
      r_byte      <= w_byte_nxt;
      r_leb_acc   <= w_leb_acc_nxt;
      r_leb_cnt   <= w_leb_cnt_nxt;
      r_hdr_idx   <= w_hdr_idx_nxt;
      r_sec_id    <= w_sec_id_nxt;
      r_sec_end   <= w_sec_end_nxt;
      r_target    <= w_target_nxt;
      r_body_idx  <= w_body_idx_nxt;
      r_local_rem <= w_local_rem_nxt;
      r_first     <= w_first_nxt;
      r_mapped    <= w_mapped_nxt;
      r_error     <= w_error_nxt;
      r_code      <= w_code_nxt;
    end
  end

  assign bus.addr           = r_addr;
  assign bus.memory_read_en = r_read_en;
  assign rom_mapped         = r_mapped;
  assign first_instruction  = r_first;
  assign parse_error        = r_error;
  assign error_code         = r_code;

endmodule
